serial_add_sequencer: RTL and testbench

//  Upstream controller for the N-bit serial adder. Accepts two parallel

---
 rtl/serial_add_sequencer.sv | 149 ++++++++++++++
 tb/tb_serial_add_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Serial-adder sequencer: load A, flush, load B, flush; done 4N+1 cycles after start (2N+1 for accum when ACCUM_EN is defined).
// Registered outputs; start is ignored while busy; optional single-operand accumulate is built only with `define ACCUM_EN.
module serial_add_sequencer #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_clr_n,
  input  logic         i_start,
  input  logic [N-1:0] i_op_a,
  input  logic [N-1:0] i_op_b,
`ifdef ACCUM_EN
  input  logic         i_accum,
`endif
  output logic         o_serial_out,
  output logic         o_shift_en,
  output logic         o_adder_clr,
  output logic         o_busy,
  output logic         o_done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_FLUSH_A,
    S_LOAD_B,
    S_FLUSH_B,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_op_a;
  logic [N-1:0]  r_op_b;
  logic          r_serial_out;
  logic          r_shift_en;
  logic          r_adder_clr;
  logic          r_busy;
  logic          r_done;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [N-1:0]  w_op_a_nxt;
  logic [N-1:0]  w_op_b_nxt;
  logic          w_last;
  logic          w_accum;
  logic          w_serial_nxt;
  logic          w_shift_nxt;
  logic          w_clr_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;

`ifdef ACCUM_EN
  assign w_accum = i_accum;
`else
  assign w_accum = 1'b0;
`endif

  assign w_last = (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_op_a_nxt  = i_op_a;
          w_op_b_nxt  = i_op_b;
          w_cnt_nxt   = '0;
          w_state_nxt = w_accum ? S_LOAD_B : S_LOAD_A;
        end
      end
      S_LOAD_A, S_FLUSH_A, S_LOAD_B, S_FLUSH_B: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          case (r_state)
            S_LOAD_A:  w_state_nxt = S_FLUSH_A;
            S_FLUSH_A: w_state_nxt = S_LOAD_B;
            S_LOAD_B:  w_state_nxt = S_FLUSH_B;
            default:   w_state_nxt = S_DONE;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register on the same edge as the state.
  always_comb begin
    w_serial_nxt = 1'b0;
    w_shift_nxt  = 1'b0;
    w_clr_nxt    = 1'b0;
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_done_nxt   = (w_state_nxt == S_DONE);
    case (w_state_nxt)
      S_LOAD_A: begin
        w_shift_nxt  = 1'b1;
        w_serial_nxt = w_op_a_nxt[w_cnt_nxt];
      end
      S_LOAD_B: begin
        w_shift_nxt  = 1'b1;
        w_serial_nxt = w_op_b_nxt[w_cnt_nxt];
      end
      S_FLUSH_A, S_FLUSH_B: begin
        w_shift_nxt = 1'b1;
        w_clr_nxt   = (w_cnt_nxt == LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_serial_out <= 1'b0;
      r_shift_en   <= 1'b0;
      r_adder_clr  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_op_a       <= w_op_a_nxt;
      r_op_b       <= w_op_b_nxt;
      r_serial_out <= w_serial_nxt;
      r_shift_en   <= w_shift_nxt;
      r_adder_clr  <= w_clr_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign o_serial_out = r_serial_out;
  assign o_shift_en   = r_shift_en;
  assign o_adder_clr  = r_adder_clr;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench: the sequencer drives a behavioural 4-bit serial adder; qa, latency and traces are checked.
module tb_serial_add_sequencer;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       start;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       accum;
  logic       serial_out;
  logic       shift_en;
  logic       adder_clr;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_sequencer #(.N(4)) dut (
    .i_clk        (clk),
    .i_clr_n      (clr_n),
    .i_start      (start),
    .i_op_a       (op_a),
    .i_op_b       (op_b),
`ifdef ACCUM_EN
    .i_accum      (accum),
`endif
    .o_serial_out (serial_out),
    .o_shift_en   (shift_en),
    .o_adder_clr  (adder_clr),
    .o_busy       (busy),
    .o_done       (done)
  );

  // Behavioural serial adder: A accumulates, B shifts in serial_input, carry cleared by clr.
  logic [3:0] mqa;
  logic [3:0] mqb;
  logic       mc;
  logic       m_zero;
  logic       m_sum;
  logic       m_co;
  assign m_sum = mqa[0] ^ mqb[0] ^ mc;
  assign m_co  = (mqa[0] & mqb[0]) | (mqa[0] & mc) | (mqb[0] & mc);

  always @(posedge clk) begin
    if (m_zero) begin
      mqa <= 4'd0;
      mqb <= 4'd0;
      mc  <= 1'b0;
    end else if (shift_en) begin
      mqa <= {m_sum, mqa[3:1]};
      mqb <= {serial_out, mqb[3:1]};
      mc  <= adder_clr ? 1'b0 : m_co;
    end
  end

  task automatic zero_model();
    @(negedge clk);
    m_zero = 1'b1;
    @(negedge clk);
    m_zero = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic acc,
                        input logic [31:0] poke, output int lat, output int nshift,
                        output int ndone, output logic [15:0] ser_tr,
                        output logic [15:0] clr_tr, output logic busy_after);
    lat = -1; nshift = 0; ndone = 0; ser_tr = '0; clr_tr = '0; busy_after = 1'b1;
    @(negedge clk);
    op_a = a; op_b = b; accum = acc; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (lat >= 0 && k == lat + 1) begin
        busy_after = busy;
        break;
      end
      if (shift_en) begin
        if (nshift < 16) begin
          ser_tr[nshift] = serial_out;
          clr_tr[nshift] = adder_clr;
        end
        nshift++;
      end
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      @(negedge clk);
      start = (k < 32) ? poke[k] : 1'b0;
      op_a = ~a; op_b = ~b; accum = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL done_timeout: done never seen within 40 cycles (a=%0d b=%0d)", a, b);
    end
  endtask

  int         lat, nsh, ndn;
  logic [15:0] ser, clt;
  logic       bsy;

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b0; op_a = 4'd0; op_b = 4'd0; accum = 1'b0; m_zero = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({serial_out, shift_en, adder_clr, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_held: outputs=%b expected 00000", {serial_out, shift_en, adder_clr, busy, done});
    end
    @(negedge clk);
    clr_n = 1'b1;
    m_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({serial_out, shift_en, adder_clr, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_release: outputs=%b expected 00000", {serial_out, shift_en, adder_clr, busy, done});
    end
  endtask

  task automatic test_add_basic();
    zero_model();
    run_op(4'd3, 4'd5, 1'b0, 32'd0, lat, nsh, ndn, ser, clt, bsy);
    checks++;
    if (mqa !== 4'd8) begin errors++; $display("FAIL add_3_5_qa: got %0d expected 8", mqa); end
    checks++;
    if (lat != 17) begin errors++; $display("FAIL add_3_5_latency: got %0d expected 17", lat); end
    checks++;
    if (nsh != 16) begin errors++; $display("FAIL add_3_5_shifts: got %0d expected 16", nsh); end
    checks++;
    if (bsy !== 1'b0) begin errors++; $display("FAIL add_3_5_busy_after: got %b expected 0", bsy); end
  endtask

  task automatic test_carry_clear();
    zero_model();
    run_op(4'd9, 4'd7, 1'b0, 32'd0, lat, nsh, ndn, ser, clt, bsy);
    checks++;
    if (mqa !== 4'd0) begin errors++; $display("FAIL add_9_7_qa: got %0d expected 0", mqa); end
    run_op(4'd1, 4'd1, 1'b0, 32'd0, lat, nsh, ndn, ser, clt, bsy);
    checks++;
    if (mqa !== 4'd2) begin errors++; $display("FAIL add_1_1_after_carry_qa: got %0d expected 2", mqa); end
    checks++;
    if (lat != 17) begin errors++; $display("FAIL back_to_back_latency: got %0d expected 17", lat); end
  endtask

  task automatic test_serial_trace();
    zero_model();
    run_op(4'b1010, 4'b0110, 1'b0, 32'd0, lat, nsh, ndn, ser, clt, bsy);
    checks++;
    if (ser !== 16'h060A) begin errors++; $display("FAIL serial_trace: got %h expected 060a", ser); end
    checks++;
    if (clt !== 16'h8080) begin errors++; $display("FAIL clr_trace: got %h expected 8080", clt); end
    checks++;
    if (mqa !== 4'd0) begin errors++; $display("FAIL trace_qa: got %0d expected 0", mqa); end
  endtask

  task automatic test_start_ignored();
    logic [31:0] pk;
    pk = '0;
    pk[3] = 1'b1; pk[10] = 1'b1; pk[17] = 1'b1;
    zero_model();
    run_op(4'd2, 4'd3, 1'b0, pk, lat, nsh, ndn, ser, clt, bsy);
    checks++;
    if (ndn != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndn); end
    checks++;
    if (mqa !== 4'd5) begin errors++; $display("FAIL ignore_qa: got %0d expected 5", mqa); end
    checks++;
    if (bsy !== 1'b0) begin errors++; $display("FAIL ignore_busy_after_done: got %b expected 0", bsy); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    op_a = 4'd6; op_b = 4'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (shift_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_active: shift_en=%b busy=%b expected 1 1", shift_en, busy);
    end
    #1;
    clr_n = 1'b0;
    #1;
    checks++;
    if ({serial_out, shift_en, adder_clr, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: outputs=%b expected 00000", {serial_out, shift_en, adder_clr, busy, done});
    end
    @(negedge clk);
    clr_n = 1'b1;
    zero_model();
    run_op(4'd2, 4'd3, 1'b0, 32'd0, lat, nsh, ndn, ser, clt, bsy);
    checks++;
    if (mqa !== 4'd5) begin errors++; $display("FAIL post_reset_qa: got %0d expected 5", mqa); end
    checks++;
    if (lat != 17) begin errors++; $display("FAIL post_reset_latency: got %0d expected 17", lat); end
  endtask

`ifdef ACCUM_EN
  task automatic test_accum();
    zero_model();
    run_op(4'd2, 4'd4, 1'b0, 32'd0, lat, nsh, ndn, ser, clt, bsy);
    checks++;
    if (mqa !== 4'd6) begin errors++; $display("FAIL accum_setup_qa: got %0d expected 6", mqa); end
    run_op(4'd0, 4'd3, 1'b1, 32'd0, lat, nsh, ndn, ser, clt, bsy);
    checks++;
    if (mqa !== 4'd9) begin errors++; $display("FAIL accum_qa: got %0d expected 9", mqa); end
    checks++;
    if (lat != 9) begin errors++; $display("FAIL accum_latency: got %0d expected 9", lat); end
    checks++;
    if (nsh != 8) begin errors++; $display("FAIL accum_shifts: got %0d expected 8", nsh); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_basic();
    test_carry_clear();
    test_serial_trace();
    test_start_ignored();
    test_mid_reset();
`ifdef ACCUM_EN
    test_accum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
